// File: rtl/zap_fetch_queue.sv
// Fetch-side instruction queue between the fetch unit and decode.
// Holds fetched words in a circular buffer and tracks wishbone fetch
// requests that are still in flight. Each request is only enabled when
// the queue is guaranteed to have room for its response. After a flush,
// responses to requests that were still in flight are dropped.
module zap_fetch_queue #(
    parameter int WDT     = 32,
    parameter int DEPTH   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear_from_writeback,
    input  logic                     i_data_stall,
    input  logic                     i_clear_from_alu,
    input  logic                     i_stall_from_shifter,
    input  logic                     i_stall_from_issue,
    input  logic                     i_stall_from_decode,
    input  logic                     i_clear_from_decode,
    input  logic                     i_req_issue,
    input  logic                     i_valid,
    input  logic [WDT-1:0]           i_instr,
    output logic [WDT-1:0]           o_instr,
    output logic                     o_valid,
    output logic                     o_wb_stb,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb_nxt,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   MAXOUT_V = (AW+1)'(MAX_OUT);
    localparam logic [AW+1:0] CREDIT_V = (AW+2)'(DEPTH);

    logic [WDT-1:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;
    logic [AW:0]    inflight;
    logic [AW:0]    inflight_nxt;
    logic [AW:0]    drop_cnt;
    logic [AW:0]    drop_nxt;
    logic [AW+1:0]  credit_sum;
    logic           clear;
    logic           rd_en;
    logic           empty;
    logic           full;
    logic           pop;
    logic           discard;
    logic           wr;
    logic           wr_blocked;

    // Resolve the clear/stall priority chain: the highest asserted input wins.
    always_comb begin
        clear = 1'b0;
        rd_en = 1'b0;
        if (i_clear_from_writeback)
            clear = 1'b1;
        else if (i_data_stall)
            clear = 1'b0;
        else if (i_clear_from_alu)
            clear = 1'b1;
        else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode)
            clear = 1'b0;
        else if (i_clear_from_decode)
            clear = 1'b1;
        else
            rd_en = 1'b1;
    end

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_V);
    assign pop        = rd_en && !empty;
    // Stale responses (and anything arriving in a clear cycle) never reach storage.
    assign discard    = i_valid && (clear || (drop_cnt != '0));
    assign wr         = i_valid && !discard && (!full || pop);
    assign wr_blocked = i_valid && !discard && full && !pop;

    // Next in-flight count; saturates at both ends on protocol errors.
    always_comb begin
        inflight_nxt = inflight;
        if (i_req_issue && !i_valid) begin
            if (inflight != MAXOUT_V)
                inflight_nxt = inflight + 1'b1;
        end else if (!i_req_issue && i_valid) begin
            if (inflight != '0)
                inflight_nxt = inflight - 1'b1;
        end
    end

    // Next occupancy and stale-response counter, used for credit and state update.
    always_comb begin
        count_nxt = count + (AW+1)'(wr) - (AW+1)'(pop);
        drop_nxt  = drop_cnt;
        if (clear) begin
            count_nxt = '0;
            drop_nxt  = inflight_nxt;
        end else if (i_valid && (drop_cnt != '0)) begin
            drop_nxt  = drop_cnt - 1'b1;
        end
    end

    // Every outstanding request must have a guaranteed slot when it returns.
    assign credit_sum   = {1'b0, count_nxt} + {1'b0, inflight_nxt};
    assign o_wb_stb_nxt = (credit_sum < CREDIT_V) && (inflight_nxt < MAXOUT_V) && !i_reset;

    // Control state: pointers, counters, output valid and request enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            o_valid  <= 1'b0;
            o_wb_stb <= 1'b0;
        end else begin
            o_wb_stb <= o_wb_stb_nxt;
            inflight <= inflight_nxt;
            drop_cnt <= drop_nxt;
            if (clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                o_valid <= 1'b0;
            end else begin
                if (wr)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (rd_en)
                    o_valid <= !empty;
            end
        end
    end

    // Data path: storage write and head-of-queue load into the output register.
    always_ff @(posedge i_clk) begin
        if (wr)
            mem[wr_ptr[AW-1:0]] <= i_instr;
        if (pop)
            o_instr <= mem[rd_ptr[AW-1:0]];
    end

    // Protocol checks: counter underflow/overflow and unmatched writes to a full queue.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(i_valid && (inflight == '0)));
            assert (!(i_req_issue && !i_valid && (inflight == MAXOUT_V)));
            assert (!wr_blocked);
        end
    end

    assign o_wb_cyc       = o_wb_stb;
    assign o_level        = count;
    assign o_drop_pending = (drop_cnt != '0);

endmodule
